// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with grant hold and an optional maximum hold limit.
// Registered one-hot grant; the priority pointer advances past each owner on release.
module rr_grant_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 16,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic               busy
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } pick_t;

  // Circular scan from start; walking offsets high-to-low lets the lowest offset win last.
  function automatic pick_t pick(input logic [NUM_REQ-1:0] mask,
                                 input logic [PTR_W-1:0]   start);
    pick_t res;
    int    idx;
    res = '{found: 1'b0, idx: '0};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx -= NUM_REQ;
      if (mask[PTR_W'(idx)]) begin
        res.found = 1'b1;
        res.idx   = PTR_W'(idx);
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_grant_valid;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_hold;

  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [CNT_W-1:0]   w_hold_nxt;

  logic               w_expired;
  logic               w_release;
  logic [PTR_W-1:0]   w_nptr;
  pick_t              w_pick_idle;
  pick_t              w_pick_rel;

  assign w_expired   = (MAX_HOLD != 0) && (r_hold == CNT_W'(MAX_HOLD));
  assign w_release   = !req[r_owner] || w_expired;
  assign w_nptr      = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_pick_idle = pick(req, r_ptr);
  assign w_pick_rel  = pick(req, w_nptr);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_idle.found) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_pick_idle.idx;
          w_grant_nxt = onehot(w_pick_idle.idx);
          w_hold_nxt  = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (!w_release) begin
          w_hold_nxt = r_hold + 1'b1;
        end else begin
          w_ptr_nxt = w_nptr;
          if (w_pick_rel.found) begin
            // Hand-over without an idle bubble; a sole expired owner re-wins here.
            w_owner_nxt = w_pick_rel.idx;
            w_grant_nxt = onehot(w_pick_rel.idx);
            w_hold_nxt  = CNT_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_hold_nxt  = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_hold_nxt  = '0;
      end
    endcase

    if (MAX_HOLD == 0) w_hold_nxt = '0;
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_ptr         <= '0;
      r_owner       <= '0;
      r_hold        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= |w_grant_nxt;
      r_ptr         <= w_ptr_nxt;
      r_owner       <= w_owner_nxt;
      r_hold        <= w_hold_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign busy        = (r_state == ST_GRANT);

endmodule
